// File: rtl/ddr3_app_ctrl_if.sv
// ddr3_app_ctrl_if: request/response stream plus MIG app-port signal bundle
interface ddr3_app_ctrl_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 512,
  parameter int RD_DEPTH = 16
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W = $clog2(RD_DEPTH + 1);
  logic init_calib_complete;
  logic req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en, app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic app_rd_data_valid, app_rd_data_end;
  logic [CNT_W-1:0] rd_outstanding;
  modport slave (
    input init_calib_complete, req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    input app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    output req_ready, rsp_valid, rsp_data, app_addr, app_cmd, app_en,
    output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end, rd_outstanding
  );
  modport master (
    output init_calib_complete, req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    input req_ready, rsp_valid, rsp_data, app_addr, app_cmd, app_en,
    input app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end, rd_outstanding
  );
endinterface

// File: rtl/ddr3_app_ctrl.sv
// ddr3_app_ctrl: valid/ready request adapter onto the MIG app port with a credit-reserved read FIFO
module ddr3_app_ctrl #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 512,
  parameter int RD_DEPTH = 16
) (
  input logic ui_clk,
  input logic ui_clk_sync_rst,
  ddr3_app_ctrl_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W = $clog2(RD_DEPTH + 1);
  localparam int PTR_W = $clog2(RD_DEPTH);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;
  logic [DATA_W-1:0] mem [RD_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic accept, rd_accept, pop, cmd_done, dat_done;
  logic unused_rd_end;
  assign unused_rd_end = bus.app_rd_data_end;
  // Read credits cover both in-flight reads and FIFO occupancy, so a return always has a slot
  always_comb begin
    bus.req_ready = state == IDLE && !ui_clk_sync_rst && bus.init_calib_complete &&
                    (bus.req_write || bus.rd_outstanding < CNT_W'(RD_DEPTH));
    accept = bus.req_valid && bus.req_ready;
    rd_accept = accept && !bus.req_write;
    bus.rsp_valid = wr_ptr != rd_ptr;
    bus.rsp_data = mem[rd_ptr[PTR_W-1:0]];
    pop = bus.rsp_valid && bus.rsp_ready;
    cmd_done = !bus.app_en || bus.app_rdy;
    dat_done = !bus.app_wdf_wren || bus.app_wdf_rdy;
  end
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state <= IDLE;
      bus.app_en <= 1'b0;
      bus.app_wdf_wren <= 1'b0;
      bus.app_wdf_end <= 1'b0;
      bus.rd_outstanding <= '0;
    end else begin
      bus.rd_outstanding <= bus.rd_outstanding + CNT_W'(rd_accept) - CNT_W'(pop);
      if (state == IDLE) begin
        if (accept) begin
          state <= ISSUE;
          bus.app_en <= 1'b1;
          bus.app_cmd <= bus.req_write ? 3'b000 : 3'b001;
          bus.app_addr <= bus.req_addr;
          bus.app_wdf_wren <= bus.req_write;
          bus.app_wdf_end <= bus.req_write;
          bus.app_wdf_data <= bus.req_wdata;
          bus.app_wdf_mask <= MASK_W'(bus.req_wmask);
        end
      end else begin
        if (bus.app_rdy) bus.app_en <= 1'b0;
        if (bus.app_wdf_rdy) begin
          bus.app_wdf_wren <= 1'b0;
          bus.app_wdf_end <= 1'b0;
        end
        if (cmd_done && dat_done) state <= IDLE;
      end
    end
  end
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (bus.app_rd_data_valid) begin
        mem[wr_ptr[PTR_W-1:0]] <= bus.app_rd_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_ddr3_app_ctrl.sv
// tb_ddr3_app_ctrl: randomized scoreboard bench with a MIG model and a transaction-level reference
module tb_ddr3_app_ctrl;
  localparam int AW = 28, DW = 512, MW = 64, DEPTH = 16;
  logic ui_clk = 0, ui_clk_sync_rst = 1;
  always #5 ui_clk = ~ui_clk;
  ddr3_app_ctrl_if bus();
  ddr3_app_ctrl dut (.ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst), .bus(bus.slave));
  typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; logic [MW-1:0] m; } req_t;
  req_t cmd_q[$], dat_q[$];
  logic [DW-1:0] exp_rd[$];
  logic [AW-1:0] ret_q[$];
  int tests = 0, fails = 0;
  int exp_out = 0, fifo_cnt = 0, en_run = 0, wr_run = 0, last_en_len = 0, last_wr_len = 0;
  bit cmd_pend = 0, dat_pend = 0, prev_hold = 0;
  logic [AW-1:0] prev_addr;
  logic [2:0] prev_cmd;
  bit rdy_force = 0, rdy_val = 0, wdf_force = 0, wdf_val = 0, ret_en = 1;
  int rsp_mode = 2;
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = {4'(i), a};
    return r;
  endfunction
  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  // MIG model: random or forced accepts, reads answered in order with an address-derived pattern
  initial begin
    bus.app_rdy = 0; bus.app_wdf_rdy = 0; bus.app_rd_data = '0;
    bus.app_rd_data_valid = 0; bus.app_rd_data_end = 0;
    forever begin
      @(posedge ui_clk); #2;
      bus.app_rdy = rdy_force ? rdy_val : ($urandom_range(0, 9) < 6);
      bus.app_wdf_rdy = wdf_force ? wdf_val : ($urandom_range(0, 9) < 6);
      if (ret_en && ret_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.app_rd_data_valid = 1; bus.app_rd_data_end = 1;
        bus.app_rd_data = pattern(ret_q.pop_front());
      end else begin
        bus.app_rd_data_valid = 0; bus.app_rd_data_end = 0;
        bus.app_rd_data = {16{$urandom}};
      end
    end
  end
  initial begin
    bus.rsp_ready = 0;
    forever begin
      @(posedge ui_clk); #3;
      bus.rsp_ready = rsp_mode == 2 ? 1'($urandom_range(0, 1)) : rsp_mode == 1;
    end
  end
  // Monitor/scoreboard: everything observed here takes effect at the following rising edge
  always @(negedge ui_clk) begin
    bit er, acc, chs, dhs, pop;
    req_t r;
    er = !ui_clk_sync_rst && !cmd_pend && !dat_pend && bus.init_calib_complete &&
         (bus.req_write || exp_out < DEPTH);
    chk("req_ready", bus.req_ready, er);
    chk("app_en", bus.app_en, cmd_pend);
    chk("app_wdf_wren", bus.app_wdf_wren, dat_pend);
    chk("app_wdf_end", bus.app_wdf_end, dat_pend);
    chk("rsp_valid", bus.rsp_valid, fifo_cnt > 0);
    chk("rd_outstanding", bus.rd_outstanding, exp_out);
    if (prev_hold) begin
      chk("addr_stable", bus.app_addr, prev_addr);
      chk("cmd_stable", bus.app_cmd, prev_cmd);
    end
    if (ui_clk_sync_rst) begin
      cmd_q.delete(); dat_q.delete(); exp_rd.delete(); ret_q.delete();
      cmd_pend = 0; dat_pend = 0; prev_hold = 0;
      exp_out = 0; fifo_cnt = 0; en_run = 0; wr_run = 0;
    end else begin
      acc = bus.req_valid && er;
      chs = cmd_pend && bus.app_rdy;
      dhs = dat_pend && bus.app_wdf_rdy;
      pop = bus.rsp_ready && fifo_cnt > 0;
      if (cmd_pend) en_run++;
      if (dat_pend) wr_run++;
      if (chs) begin
        last_en_len = en_run; en_run = 0; cmd_pend = 0;
        r = cmd_q.pop_front();
        chk("app_cmd", bus.app_cmd, r.w ? 3'b000 : 3'b001);
        chk("app_addr", bus.app_addr, r.a);
        if (!r.w) ret_q.push_back(bus.app_addr);
      end
      if (dhs) begin
        last_wr_len = wr_run; wr_run = 0; dat_pend = 0;
        r = dat_q.pop_front();
        chk("app_wdf_data", bus.app_wdf_data, r.d);
        chk("app_wdf_mask", bus.app_wdf_mask, r.m);
      end
      if (pop) chk("rsp_data", bus.rsp_data, exp_rd.pop_front());
      prev_hold = cmd_pend;
      prev_addr = bus.app_addr;
      prev_cmd = bus.app_cmd;
      if (acc) begin
        r.w = bus.req_write; r.a = bus.req_addr; r.d = bus.req_wdata; r.m = bus.req_wmask;
        cmd_q.push_back(r);
        cmd_pend = 1;
        if (r.w) begin
          dat_q.push_back(r);
          dat_pend = 1;
        end else exp_rd.push_back(pattern(r.a));
      end
      fifo_cnt += int'(bus.app_rd_data_valid) - int'(pop);
      exp_out += int'(acc && !bus.req_write) - int'(pop);
    end
  end
  task automatic tick();
    @(posedge ui_clk); #1;
  endtask
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    int n = 0;
    bus.req_valid = 1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d; bus.req_wmask = m;
    do begin
      @(negedge ui_clk);
      n++;
    end while (!bus.req_ready && n < 300);
    if (!bus.req_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: req_ready got 0 expected 1 at %0t", $time);
    end
    tick();
    bus.req_valid = 0;
  endtask
  task automatic wait_until(input string name, input int what);
    int n = 0;
    while (n < 1000 && (what == 0 ? (cmd_pend || dat_pend) :
           what == 1 ? (cmd_pend || dat_pend || exp_out != 0 || fifo_cnt != 0) :
           (ret_q.size() != 0 || fifo_cnt != DEPTH))) begin
      tick();
      n++;
    end
    if (n >= 1000) begin
      tests++; fails++;
      $display("FAIL %s_timeout: condition got 0 expected 1 at %0t", name, $time);
    end
  endtask
  initial begin
    bus.init_calib_complete = 0; bus.req_valid = 1; bus.req_write = 0;
    bus.req_addr = AW'('h40); bus.req_wdata = '0; bus.req_wmask = '0;
    repeat (5) begin
      @(negedge ui_clk);
      chk("t1_ready_in_reset", bus.req_ready, 0);
      chk("t1_en_in_reset", bus.app_en, 0);
    end
    tick(); ui_clk_sync_rst = 0;
    @(negedge ui_clk); chk("t1_ready_no_calib", bus.req_ready, 0);
    tick(); bus.init_calib_complete = 1;
    @(negedge ui_clk); chk("t1_ready_after_calib", bus.req_ready, 1);
    tick(); bus.req_valid = 0;
    wait_until("t1_drain", 1);
    rdy_force = 1; rdy_val = 0; wdf_force = 1; wdf_val = 1;
    send(1, AW'('h100), {64{8'hA5}}, '0);
    repeat (3) tick();
    rdy_val = 1;
    tick(); rdy_force = 0; wdf_force = 0;
    @(negedge ui_clk);
    chk("t2_en_len", last_en_len, 4);
    chk("t2_wren_len", last_wr_len, 1);
    chk("t2_idle_ready", bus.req_ready, 1);
    tick();
    rdy_force = 1; rdy_val = 1; wdf_force = 1; wdf_val = 1;
    send(1, AW'('h2345), {16{32'h1234_5678}}, {2{32'h0F0F_00FF}});
    @(negedge ui_clk); chk("t3_busy", bus.req_ready, 0);
    @(negedge ui_clk); chk("t3_ready_back", bus.req_ready, 1);
    chk("t3_en_len", last_en_len, 1);
    chk("t3_wren_len", last_wr_len, 1);
    tick(); rdy_force = 0; wdf_force = 0;
    wait_until("t3_drain", 1);
    rsp_mode = 0; ret_en = 0;
    for (int i = 0; i < DEPTH; i++) send(0, AW'($urandom), '0, '0);
    wait_until("t4_issue", 0);
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = AW'('h777);
    repeat (3) begin
      @(negedge ui_clk);
      chk("t4_read_blocked", bus.req_ready, 0);
    end
    chk("t4_outstanding", bus.rd_outstanding, DEPTH);
    tick(); bus.req_valid = 0;
    send(1, AW'('h999), {16{$urandom}}, '0);
    ret_en = 1;
    wait_until("t4_fill", 2);
    @(negedge ui_clk);
    chk("t4_full_valid", bus.rsp_valid, 1);
    chk("t4_full_count", bus.rd_outstanding, DEPTH);
    tick();
    rsp_mode = 1;
    send(0, AW'('h5555), '0, '0);
    @(negedge ui_clk); chk("t5_count", bus.rd_outstanding, DEPTH - 1);
    tick(); rsp_mode = 2;
    for (int i = 0; i < 4; i++) send(0, AW'($urandom), '0, '0);
    wait_until("t5_drain", 1);
    for (int i = 0; i < 250; i++) begin
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), {16{$urandom}}, {$urandom, $urandom});
      if ($urandom_range(0, 9) == 0) begin
        bus.init_calib_complete = 0;
        repeat (3) tick();
        bus.init_calib_complete = 1;
      end
      if ($urandom_range(0, 7) == 0) rsp_mode = $urandom_range(0, 2);
      else if (rsp_mode == 0 && exp_out == DEPTH) rsp_mode = 2;
    end
    rsp_mode = 2;
    wait_until("rand_drain", 1);
    ret_en = 0;
    send(0, AW'('h11), '0, '0);
    send(0, AW'('h22), '0, '0);
    wait_until("t6_issue", 0);
    rdy_force = 1; rdy_val = 0; wdf_force = 1; wdf_val = 0;
    send(1, AW'('h33), {16{32'hCAFE_F00D}}, '0);
    ui_clk_sync_rst = 1;
    @(negedge ui_clk); chk("t6_en_before", bus.app_en, 1);
    tick(); ui_clk_sync_rst = 0;
    @(negedge ui_clk);
    chk("t6_en_after", bus.app_en, 0);
    chk("t6_wren_after", bus.app_wdf_wren, 0);
    chk("t6_end_after", bus.app_wdf_end, 0);
    chk("t6_outstanding", bus.rd_outstanding, 0);
    tick(); rdy_force = 0; wdf_force = 0; ret_en = 1;
    for (int i = 0; i < 10; i++) send(1'($urandom_range(0, 1)), AW'($urandom), {16{$urandom}}, '0);
    wait_until("final_drain", 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: finished got 0 expected 1");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule
